seg_scan_mux: RTL

//  Time-multiplexed 6-digit 7-segment display driver placed directly downstream of the

---
 rtl/seg_scan_mux_if.sv | 42 ++++
 rtl/seg_scan_mux.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if
// Groups the data path of the six-digit display driver: the per-digit
// segment patterns and status flags coming from the clock/alarm core, and
// the multiplexed segment/digit-enable lines going to the display.
// Signals:
//   H1,H2,M1,M2,S1,S2  7  per-digit segment patterns, active-low, bit6=a .. bit0=g
//   PM                 1  lights the decimal point of digit H2
//   ON                 1  1 = full brightness, 0 = dimmed
//   SND                1  alarm sounding, blinks every digit
//   blink_mask         6  per-digit blink enable, bit0=H1 .. bit5=S2
//   SEG                7  shared segment bus, active-low
//   DP                 1  shared decimal point, active-low
//   AN                 6  digit enables, active-low, bit0=H1 .. bit5=S2
//   frame_tick         1  one-cycle pulse when the digit index wraps 5 -> 0
// Modports: master drives the patterns/flags and watches the display lines;
// slave is the driver itself.
interface seg_scan_mux_if;
    logic [6:0] H1;
    logic [6:0] H2;
    logic [6:0] M1;
    logic [6:0] M2;
    logic [6:0] S1;
    logic [6:0] S2;
    logic       PM;
    logic       ON;
    logic       SND;
    logic [5:0] blink_mask;
    logic [6:0] SEG;
    logic       DP;
    logic [5:0] AN;
    logic       frame_tick;

    modport master (
        output H1, H2, M1, M2, S1, S2, PM, ON, SND, blink_mask,
        input  SEG, DP, AN, frame_tick
    );

    modport slave (
        input  H1, H2, M1, M2, S1, S2, PM, ON, SND, blink_mask,
        output SEG, DP, AN, frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Time-multiplexed six-digit seven-segment display driver. Scans one digit
// per slot onto a shared segment bus, with an all-dark window at the start
// of every slot (anti-ghost), frame-coherent latching of the digit data,
// blink, dimming and leading-zero blanking of the hour tens digit.
// Ports:
//   Cp     in  1  clock, rising edge
//   reset  in  1  asynchronous, active-low (0 = reset)
//   bus    seg_scan_mux_if.slave
//          in : H1,H2,M1,M2,S1,S2 patterns, PM, ON, SND, blink_mask
//          out: SEG, DP, AN, frame_tick (all registered)
// Parameters:
//   SCAN_DIV      clock cycles per digit slot (>= BLANK_CYC+4)
//   BLANK_CYC     all-dark cycles at the start of each slot
//   BLINK_FRAMES  frames per blink half-period
//   LZ_EN         nonzero blanks H1 when it shows "0"
module seg_scan_mux #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int LZ_EN        = 1
) (
    input  logic          Cp,
    input  logic          reset,
    seg_scan_mux_if.slave bus
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);
    localparam logic [DW-1:0] DIM_START = DW'(BLANK_CYC + (SCAN_DIV - BLANK_CYC) / 4);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

    localparam logic [6:0] ZERO_PAT = 7'b0000001;
    localparam logic [6:0] IDLE_SEG = 7'h7F;

    // With no anti-ghost window every slot starts directly in DRIVE.
    localparam slot_state_t STATE_INIT = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

    slot_state_t   state;
    logic [DW-1:0] div;
    logic [DW-1:0] div_inc;
    logic [2:0]    idx;
    logic [FW-1:0] frm;
    logic          phase;
    logic          slot_wrap;
    logic          frame_wrap;

    logic [6:0]    lat_h1;
    logic [6:0]    lat_h2;
    logic [6:0]    lat_m1;
    logic [6:0]    lat_m2;
    logic [6:0]    lat_s1;
    logic [6:0]    lat_s2;
    logic          lat_pm;

    logic [6:0]    cur_pat;
    logic          dim_cut;
    logic          blink_cut;
    logic          lz_cut;
    logic          force_blank;

    // Slot and frame boundaries derived from the current counter values.
    always_comb begin
        div_inc    = div + DW'(1);
        slot_wrap  = (div == DIV_LAST);
        frame_wrap = slot_wrap && (idx == 3'd5);
    end

    // Slot divider, digit index, slot FSM and blink timebase. The state
    // register mirrors whether the current div value lies inside the
    // anti-ghost window, so it is reloaded on every slot wrap and moves to
    // DRIVE on the cycle div reaches BLANK_CYC.
    always_ff @(posedge Cp or negedge reset) begin
        if (!reset) begin
            div   <= '0;
            idx   <= 3'd0;
            state <= STATE_INIT;
            frm   <= '0;
            phase <= 1'b0;
        end else begin
            if (slot_wrap) begin
                div   <= '0;
                idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                state <= STATE_INIT;
            end else begin
                div <= div_inc;
                if (div_inc == BLANK_END) begin
                    state <= ST_DRIVE;
                end
            end
            if (frame_wrap) begin
                if (frm == FRM_LAST) begin
                    frm   <= '0;
                    phase <= ~phase;
                end else begin
                    frm <= frm + FW'(1);
                end
            end
        end
    end

    // Digit data is captured only on the frame wrap, so a frame always shows
    // one coherent snapshot of the time; until the first wrap the display
    // shows blank patterns.
    always_ff @(posedge Cp or negedge reset) begin
        if (!reset) begin
            lat_h1 <= IDLE_SEG;
            lat_h2 <= IDLE_SEG;
            lat_m1 <= IDLE_SEG;
            lat_m2 <= IDLE_SEG;
            lat_s1 <= IDLE_SEG;
            lat_s2 <= IDLE_SEG;
            lat_pm <= 1'b0;
        end else if (frame_wrap) begin
            lat_h1 <= bus.H1;
            lat_h2 <= bus.H2;
            lat_m1 <= bus.M1;
            lat_m2 <= bus.M2;
            lat_s1 <= bus.S1;
            lat_s2 <= bus.S2;
            lat_pm <= bus.PM;
        end
    end

    // Pattern of the digit currently being scanned.
    always_comb begin
        cur_pat = IDLE_SEG;
        case (idx)
            3'd0:    cur_pat = lat_h1;
            3'd1:    cur_pat = lat_h2;
            3'd2:    cur_pat = lat_m1;
            3'd3:    cur_pat = lat_m2;
            3'd4:    cur_pat = lat_s1;
            3'd5:    cur_pat = lat_s2;
            default: cur_pat = IDLE_SEG;
        endcase
    end

    // All blanking sources drive the same idle values, so their relative
    // priority never changes the visible result; they are simply OR-ed.
    // ON, SND and blink_mask act immediately and are not frame-latched.
    always_comb begin
        dim_cut     = !bus.ON && (div >= DIM_START);
        blink_cut   = phase && (bus.blink_mask[idx] || bus.SND);
        lz_cut      = (LZ_EN != 0) && (idx == 3'd0) && (lat_h1 == ZERO_PAT);
        force_blank = (state == ST_BLANK) || dim_cut || blink_cut || lz_cut;
    end

    // Registered display outputs: one cycle behind the counters, and forced
    // idle the moment reset is asserted.
    always_ff @(posedge Cp or negedge reset) begin
        if (!reset) begin
            bus.SEG        <= IDLE_SEG;
            bus.DP         <= 1'b1;
            bus.AN         <= 6'h3F;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.frame_tick <= frame_wrap;
            if (force_blank) begin
                bus.SEG <= IDLE_SEG;
                bus.DP  <= 1'b1;
                bus.AN  <= 6'h3F;
            end else begin
                bus.SEG <= cur_pat;
                bus.DP  <= ~((idx == 3'd1) && lat_pm);
                bus.AN  <= ~(6'b000001 << idx);
            end
        end
    end

endmodule
